wb_core_master: RTL and testbench
=================================

// Module: wb_core_master
// PURPOSE
//   Wishbone B4 classic master: converts a core-side load/store request (valid/ready) into one single-beat
//   Wishbone cycle and returns aligned, extended read data or an error. Initiator counterpart of the
//   wishbone_slave-based memory wrappers; sits between a core LSU/fetch port and the bus/interconnect.
// PARAMETERS
//   TIMEOUT   256   bus cycles in BUS state before abort (used only with WB_TIMEOUT_EN); >=2
// PORTS
//   clk             in   1   clock, all logic on rising edge
//   rstn_i          in   1   asynchronous active-low reset
//   req_valid_i     in   1   core request valid
//   req_ready_o     out  1   request accepted when valid&ready
//   req_addr_i      in   32  byte address
//   req_we_i        in   1   1=store, 0=load
//   req_size_i      in   2   0=byte, 1=half, 2=word, 3=illegal
//   req_unsigned_i  in   1   load zero-extends when 1, sign-extends when 0
//   req_wdata_i     in   32  store data, LSB-aligned
//   rsp_valid_o     out  1   response valid, held until rsp_ready_i
//   rsp_ready_i     in   1   core accepts response
//   rsp_rdata_o     out  32  load data, aligned and extended; 0 for stores and errors
//   rsp_err_o       out  1   bus error, misalignment or timeout
//   wb_cyc_o        out  1   Wishbone cycle
//   wb_stb_o        out  1   Wishbone strobe
//   wb_we_o         out  1   Wishbone write enable
//   wb_adr_o        out  32  word address {addr[31:2],2'b00}
//   wb_sel_o        out  4   byte selects
//   wb_dat_o        out  32  write data (lane-replicated)
//   wb_dat_i        in   32  read data
//   wb_ack_i        in   1   slave acknowledge
//   wb_err_i        in   1   slave error
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 except req_ready_o=1 (IDLE); async assert drops cyc/stb immediately.
//   FSM: IDLE -> BUS on accepted legal request; IDLE -> RESP on accepted misaligned/illegal request
//     (no bus cycle, rsp_err_o=1); BUS -> RESP on wb_ack_i|wb_err_i (or timeout); RESP -> IDLE on rsp_ready_i.
//   req_ready_o = (state==IDLE). Request fields registered on acceptance; inputs ignored afterwards.
//   BUS: wb_cyc_o=wb_stb_o=1, adr/we/sel/dat stable from registered request. ack/err sampled each cycle;
//     cyc/stb deassert the cycle after ack/err is seen. ack and err together -> err wins.
//   Latency: accept T0, cyc/stb T1, ack at T1 -> rsp_valid_o at T2; next request accepted T3 earliest.
//   Misaligned: half with addr[0]=1, word with addr[1:0]!=0, size 3 -> error response.
//   sel: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//   wdata: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
//   rdata: wb_dat_i >> (8*addr[1:0]) captured on ack, then sign/zero extend to 32 by size.
//   RESP: rsp_valid_o, rsp_rdata_o, rsp_err_o stable until rsp_ready_i; ack/err outside BUS ignored.
// CONFIGURATION
//   WB_TIMEOUT_EN defined: counter cleared on BUS entry, increments each BUS cycle; when it reaches TIMEOUT
//     without ack/err, cyc/stb drop next cycle, RESP with rsp_err_o=1, rsp_rdata_o=0.
//   WB_TIMEOUT_EN undefined: no counter, TIMEOUT unused, BUS waits indefinitely for ack/err.
// STRUCTURE
//   Package wb_master_pkg: size enum (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL), state enum (IDLE/BUS/RESP),
//     misalign check function, SEL_BYTE/SEL_HALF/SEL_WORD constants.
//   Sub-module wb_lsu_align: combinational sel generation, wdata replication, rdata shift/extend.
// TESTING
//   Word load 0x100, slave acks at T1 with 0xDEADBEEF -> sel=4'hF, adr=0x100, rsp_rdata_o=0xDEADBEEF at T2.
//   Signed byte load 0x103, wb_dat_i=0x80xxxxxx -> sel=4'b1000, rsp_rdata_o=0xFFFFFF80; unsigned -> 0x00000080.
//   Half store 0x202 data 0x1234ABCD -> sel=4'b1100, wb_dat_o=0xABCDABCD, we=1, rsp_err_o=0, rdata=0.
//   Word load 0x101 -> no cyc asserted, rsp_valid_o with rsp_err_o=1 next cycle; ack+err same cycle -> err=1.
//   rsp_ready_i held 0 for 5 cycles -> response stable, req_ready_o=0; reset during BUS -> cyc/stb 0 at once.
//   WB_TIMEOUT_EN, TIMEOUT=4, no ack -> cyc drops after 4 BUS cycles, rsp_err_o=1; undefined -> cyc held.

Source files
------------

// File: rtl/wb_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_master_pkg
//   Shared types and helpers for the Wishbone B4 classic core master.
//   - size_e  : core access size encoding (byte/half/word/illegal)
//   - state_e : master FSM states (IDLE/BUS/RESP)
//   - SEL_*   : unshifted byte-select patterns per access size
//   - is_misaligned() : alignment/legality check applied at request accept
// ---------------------------------------------------------------------------
package wb_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Returns 1 when the access cannot be issued as a single naturally
  // aligned bus beat; size 3 is always rejected.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = addr_lo[0];
      SZ_WORD: r = |addr_lo;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_lsu_align.sv
// ---------------------------------------------------------------------------
// wb_lsu_align
//   Purely combinational lane steering between the core and a 32-bit
//   Wishbone data path.
//   Ports:
//     i_size     access size (size_e)
//     i_addr_lo  byte offset within the word
//     i_unsigned 1 = zero-extend loads, 0 = sign-extend
//     i_wdata    LSB-aligned store data from the core
//     i_rdata    raw bus read data (wb_dat_i)
//     o_sel      byte selects
//     o_wdata    store data replicated across all lanes
//     o_rdata    read data shifted down to bit 0 and extended to 32 bits
// ---------------------------------------------------------------------------
module wb_lsu_align
  import wb_master_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  always_comb begin
    w_shift = i_rdata >> {i_addr_lo, 3'b000};
    o_sel   = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_size)
      SZ_BYTE: begin
        o_sel   = SEL_BYTE << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'h0, w_shift[7:0]}
                             : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_sel   = SEL_HALF << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = i_unsigned ? {16'h0, w_shift[15:0]}
                             : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      SZ_WORD: begin
        o_sel   = SEL_WORD;
        o_wdata = i_wdata;
        o_rdata = w_shift;
      end
      // Illegal size never reaches the bus; leave everything quiet.
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_core_master.sv
// ---------------------------------------------------------------------------
// wb_core_master
//   Wishbone B4 classic master. Turns one core load/store request into one
//   single-beat Wishbone cycle and returns aligned, extended read data or an
//   error (bus error, misalignment/illegal size, optional timeout).
//
//   Parameter TIMEOUT : BUS cycles before abort (only with WB_TIMEOUT_EN, >=2)
//   Config macro      : WB_TIMEOUT_EN enables the bus timeout counter; when
//                       undefined the master waits indefinitely for ack/err.
//
//   Ports:
//     clk, rstn_i                      clock, async active-low reset
//     req_valid_i/req_ready_o          core request handshake
//     req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i
//     rsp_valid_o/rsp_ready_i          core response handshake
//     rsp_rdata_o, rsp_err_o           response payload
//     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
//     wb_dat_i, wb_ack_i, wb_err_i     Wishbone master side
//     dbg_state_o                      current FSM state (state_e encoding)
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. The request side is ready only in IDLE; the response is
//   held (valid, data, err stable) until the core asserts rsp_ready_i.
// ---------------------------------------------------------------------------
module wb_core_master
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
)(
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  dbg_state_o
);

  state_e      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_we;
  logic        r_uns;
  logic        r_err;
  size_e       r_size;

  logic        w_in_bus;
  logic        w_misalign;
  logic        w_timeout;
  logic        w_done;
  logic        w_bus_err;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat;
  logic [31:0] w_rext;

  assign w_in_bus   = (r_state == BUS);
  assign w_misalign = is_misaligned(size_e'(req_size_i), req_addr_i[1:0]);

`ifdef WB_TIMEOUT_EN
  // Counter holds 0 outside BUS, so it is implicitly cleared on BUS entry.
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i)        r_cnt <= '0;
    else if (!w_in_bus) r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end

  // Fires during the TIMEOUT-th BUS cycle, so cyc/stb are high for
  // exactly TIMEOUT cycles when the slave never answers.
  assign w_timeout = w_in_bus && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  assign w_done    = w_in_bus && (wb_ack_i || wb_err_i || w_timeout);
  // err beats ack; a timeout only counts when the slave stayed silent.
  assign w_bus_err = wb_err_i || (!wb_ack_i && w_timeout);

  wb_lsu_align u_align (
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_rdata    (wb_dat_i),
    .o_sel      (w_sel),
    .o_wdata    (w_wdat),
    .o_rdata    (w_rext)
  );

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= SZ_BYTE;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_we    <= req_we_i;
            r_uns   <= req_unsigned_i;
            r_size  <= size_e'(req_size_i);
            r_rdata <= 32'h0;
            r_err   <= w_misalign;
            // Rejected accesses skip the bus and answer with an error.
            r_state <= w_misalign ? RESP : BUS;
          end
        end
        BUS: begin
          if (w_done) begin
            r_err   <= w_bus_err;
            r_rdata <= (w_bus_err || r_we) ? 32'h0 : w_rext;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == RESP);
  assign rsp_rdata_o = rsp_valid_o ? r_rdata : 32'h0;
  assign rsp_err_o   = rsp_valid_o & r_err;

  // Bus outputs are gated so the interconnect sees an idle master outside BUS.
  assign wb_cyc_o    = w_in_bus;
  assign wb_stb_o    = w_in_bus;
  assign wb_we_o     = w_in_bus & r_we;
  assign wb_adr_o    = w_in_bus ? {r_addr[31:2], 2'b00} : 32'h0;
  assign wb_sel_o    = w_in_bus ? w_sel : 4'b0000;
  assign wb_dat_o    = w_in_bus ? w_wdat : 32'h0;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_core_master.sv
// ---------------------------------------------------------------------------
// tb_wb_core_master
//   Directed and randomized checks of wb_core_master against a lane/extension
//   model written with plain arithmetic. Built with TIMEOUT=4 so the timeout
//   behaviour is observable when WB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_wb_core_master;

  localparam int W = 33;  // {err, rdata}

  logic        clk;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [1:0]  dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  wb_core_master #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rstn_i         (rstn_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic model_bad(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    return (int'(addr[1:0]) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [31:0] addr, input logic [1:0] size);
    int m;
    m = ((1 << nbytes(size)) - 1) << addr[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdat(input logic [31:0] d, input logic [1:0] size);
    logic [31:0] r;
    int nb;
    nb = nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] model_rsp(input logic [31:0] addr, input logic we,
                                             input logic [1:0] size, input logic uns,
                                             input logic [31:0] bdat, input logic berr);
    logic [31:0] v, mask;
    int nb;
    if (model_bad(addr, size) || berr) return {1'b1, 32'h0};
    if (we) return {1'b0, 32'h0};
    nb   = nbytes(size);
    v    = bdat >> (8 * int'(addr[1:0]));
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v    = v & mask;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return {1'b0, v};
  endfunction

  // ---------------- response drain (scoreboard pop) ----------------
  task automatic drain_rsp(input string tag, input int hold);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    for (int k = 0; k < hold; k++) begin
      check({tag, " hold_valid"}, {31'h0, rsp_valid_o}, 32'h1);
      check({tag, " hold_rdata"}, rsp_rdata_o, e[31:0]);
      check({tag, " hold_err"},   {31'h0, rsp_err_o}, {31'h0, e[32]});
      check({tag, " hold_ready"}, {31'h0, req_ready_o}, 32'h0);
      // Stray slave strobes outside BUS must have no effect.
      wb_ack_i = 1'($urandom_range(0, 1));
      wb_err_i = 1'($urandom_range(0, 1));
      wb_dat_i = $urandom;
      tick();
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    check({tag, " rsp_valid"}, {31'h0, rsp_valid_o}, 32'h1);
    check({tag, " rsp_rdata"}, rsp_rdata_o, e[31:0]);
    check({tag, " rsp_err"},   {31'h0, rsp_err_o}, {31'h0, e[32]});
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check({tag, " post_valid"}, {31'h0, rsp_valid_o}, 32'h0);
    check({tag, " post_ready"}, {31'h0, req_ready_o}, 32'h1);
  endtask

  // ---------------- driver: one full transaction ----------------
  task automatic do_txn(input string tag, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] bdat, input int delay,
                        input logic ack, input logic err, input int hold);
    logic bad;
    bad = model_bad(addr, size);
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_addr_i     = addr;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_wdata_i    = wdata;
    check({tag, " req_ready"}, {31'h0, req_ready_o}, 32'h1);
    exp_q.push_back(model_rsp(addr, we, size, uns, bdat, err));
    tick();
    // Request fields must be ignored once accepted.
    req_valid_i    = 1'b0;
    req_addr_i     = $urandom;
    req_we_i       = 1'($urandom_range(0, 1));
    req_size_i     = 2'($urandom_range(0, 3));
    req_unsigned_i = 1'($urandom_range(0, 1));
    req_wdata_i    = $urandom;
    if (bad) begin
      check({tag, " bad_nocyc"}, {31'h0, wb_cyc_o}, 32'h0);
      check({tag, " bad_nostb"}, {31'h0, wb_stb_o}, 32'h0);
    end else begin
      for (int k = 0; k <= delay; k++) begin
        check({tag, " cyc"}, {31'h0, wb_cyc_o}, 32'h1);
        check({tag, " stb"}, {31'h0, wb_stb_o}, 32'h1);
        check({tag, " we"},  {31'h0, wb_we_o}, {31'h0, we});
        check({tag, " adr"}, wb_adr_o, {addr[31:2], 2'b00});
        check({tag, " sel"}, {28'h0, wb_sel_o}, {28'h0, model_sel(addr, size)});
        if (we) check({tag, " dat_o"}, wb_dat_o, model_wdat(wdata, size));
        if (k < delay) tick();
      end
      wb_ack_i = ack;
      wb_err_i = err;
      wb_dat_i = bdat;
      tick();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      check({tag, " cyc_drop"}, {31'h0, wb_cyc_o}, 32'h0);
    end
    drain_rsp(tag, hold);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [1:0] sz;
    logic e;

    rstn_i = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'h0; req_we_i = 1'b0;
    req_size_i = 2'd0; req_unsigned_i = 1'b0; req_wdata_i = 32'h0;
    rsp_ready_i = 1'b0; wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #12;
    check("rst req_ready", {31'h0, req_ready_o}, 32'h1);
    check("rst rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("rst rsp_err",   {31'h0, rsp_err_o}, 32'h0);
    check("rst rdata",     rsp_rdata_o, 32'h0);
    check("rst cyc",       {31'h0, wb_cyc_o}, 32'h0);
    check("rst stb",       {31'h0, wb_stb_o}, 32'h0);
    check("rst we",        {31'h0, wb_we_o}, 32'h0);
    check("rst adr",       wb_adr_o, 32'h0);
    check("rst sel",       {28'h0, wb_sel_o}, 32'h0);
    @(negedge clk);
    rstn_i = 1'b1;

    // Directed cases
    do_txn("ld_word",  32'h100, 1'b0, 2'd2, 1'b0, 32'h0,      32'hDEADBEEF, 0, 1'b1, 1'b0, 0);
    do_txn("ld_sbyte", 32'h103, 1'b0, 2'd0, 1'b0, 32'h0,      32'h80123456, 0, 1'b1, 1'b0, 0);
    do_txn("ld_ubyte", 32'h103, 1'b0, 2'd0, 1'b1, 32'h0,      32'h80123456, 1, 1'b1, 1'b0, 0);
    do_txn("st_half",  32'h202, 1'b1, 2'd1, 1'b0, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1'b1, 1'b0, 0);
    do_txn("ld_shalf", 32'h302, 1'b0, 2'd1, 1'b0, 32'h0,      32'h9ABC0000, 0, 1'b1, 1'b0, 1);
    do_txn("mis_word", 32'h101, 1'b0, 2'd2, 1'b0, 32'h0,      32'h0,        0, 1'b1, 1'b0, 0);
    do_txn("mis_half", 32'h105, 1'b1, 2'd1, 1'b0, 32'h5555,   32'h0,        0, 1'b1, 1'b0, 0);
    do_txn("ill_size", 32'h100, 1'b0, 2'd3, 1'b0, 32'h0,      32'h0,        0, 1'b1, 1'b0, 0);
    do_txn("ack_err",  32'h400, 1'b0, 2'd2, 1'b0, 32'h0,      32'h12345678, 0, 1'b1, 1'b1, 0);
    do_txn("err_only", 32'h401, 1'b1, 2'd0, 1'b0, 32'h77,     32'h0,        2, 1'b0, 1'b1, 0);
    do_txn("hold5",    32'h500, 1'b0, 2'd2, 1'b1, 32'h0,      32'hCAFEF00D, 0, 1'b1, 1'b0, 5);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      e  = ($urandom_range(0, 5) == 0);
      do_txn("rand", $urandom, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom_range(0, 2), ~e | 1'($urandom_range(0, 1)), e,
             $urandom_range(0, 3));
    end

    // Reset asserted mid-BUS must drop cyc/stb without waiting for an edge
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 32'h600; req_we_i = 1'b0; req_size_i = 2'd2;
    tick();
    req_valid_i = 1'b0;
    check("rstbus cyc_before", {31'h0, wb_cyc_o}, 32'h1);
    #2 rstn_i = 1'b0;
    #1;
    check("rstbus cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("rstbus stb", {31'h0, wb_stb_o}, 32'h0);
    check("rstbus ready", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk);
    rstn_i = 1'b1;
    tick();
    check("rstbus post_valid", {31'h0, rsp_valid_o}, 32'h0);

    // Slave never answers
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 32'h700; req_we_i = 1'b0; req_size_i = 2'd2;
    req_unsigned_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    wb_dat_i = 32'h13572468;
    cnt = 0;
`ifdef WB_TIMEOUT_EN
    for (int k = 0; k < 10; k++) begin
      if (!wb_cyc_o) break;
      cnt++;
      tick();
    end
    check("tmo cyc_cycles", cnt, 4);
    exp_q.push_back({1'b1, 32'h0});
    drain_rsp("tmo", 1);
`else
    for (int k = 0; k < 20; k++) begin
      if (wb_cyc_o) cnt++;
      tick();
    end
    check("notmo cyc_held", cnt, 20);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    exp_q.push_back({1'b0, 32'h13572468});
    drain_rsp("notmo", 0);
`endif

    check("scoreboard empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
